// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard/sequencing controller:
// mul/div FSM states, forwarding selects, register-address width and match helpers.
package pipeline_ctrl_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 6;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } md_state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // A producer matches a consumer only when it writes a non-zero register.
    function automatic logic reg_hit(
        input logic             we,
        input logic [REG_W-1:0] dst,
        input logic [REG_W-1:0] src
    );
        return we & (dst != {REG_W{1'b0}}) & (dst == src);
    endfunction

    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] src,
        input logic             we_m,
        input logic [REG_W-1:0] dst_m,
        input logic             we_w,
        input logic [REG_W-1:0] dst_w
    );
        logic [1:0] sel;
        if (reg_hit(we_m, dst_m, src)) begin
            sel = FWD_M;
        end else if (reg_hit(we_w, dst_w, src)) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipeline_md_timer.sv
// Mul/div occupancy timer: RUN/MD_BUSY FSM with a 6-bit down-counter that
// freezes the front end for the full execute-stage latency of a mul/div.
import pipeline_ctrl_pkg::*;

module pipeline_md_timer #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic op,
    output logic hold,
    output logic busy,
    output logic done
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    md_state_e        state_r;
    md_state_e        state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             hold_s;
    logic             done_s;

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state, counter load/decrement and end-of-operation detection.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        hold_s  = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (start) begin
                    state_s = ST_MD_BUSY;
                    cnt_s   = op ? DIV_LOAD : MUL_LOAD;
                    hold_s  = 1'b1;
                end else begin
                    state_s = ST_RUN;
                    cnt_s   = CNT_ZERO;
                end
            end
            ST_MD_BUSY: begin
                hold_s = 1'b1;
                // A zero count here is unreachable; treat it as finished rather than wrap.
                if (cnt_r <= CNT_ONE) begin
                    done_s  = 1'b1;
                    state_s = ST_RUN;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_MD_BUSY;
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s = ST_RUN;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Outputs are forced low while reset is held, even mid-operation.
    always_comb begin
        if (rst) begin
            hold = 1'b0;
            busy = 1'b0;
            done = 1'b0;
        end else begin
            hold = hold_s;
            busy = (state_r == ST_MD_BUSY);
            done = done_s;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard, forwarding and mul/div sequencing controller for the 5-stage pipeline.
// Optional PIPE_CTRL_PERF_EN adds stallCycles/flushCount performance counters.
import pipeline_ctrl_pkg::*;

module pipeline_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rsD,
    input  logic [REG_W-1:0] rtD,
    input  logic [REG_W-1:0] rsE,
    input  logic [REG_W-1:0] rtE,
    input  logic [REG_W-1:0] writeRegE,
    input  logic [REG_W-1:0] writeRegM,
    input  logic [REG_W-1:0] writeRegW,
    input  logic             regWriteE,
    input  logic             regWriteM,
    input  logic             regWriteW,
    input  logic             memToRegE,
    input  logic             memToRegM,
    input  logic             branchD,
    input  logic             pcSrcD,
    input  logic             mdStartE,
    input  logic             mdOpE,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             forwardAD,
    output logic             forwardBD,
    output logic             mdBusy,
    output logic             mdDone
`ifdef PIPE_CTRL_PERF_EN
   ,output logic [31:0]      stallCycles,
    output logic [31:0]      flushCount
`endif
);

    logic hold_s;
    logic lu_s;
    logic br_s;
    logic haz_s;
    logic stall_s;

    pipeline_md_timer #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_timer (
        .clk   (clk),
        .rst   (rst),
        .start (mdStartE),
        .op    (mdOpE),
        .hold  (hold_s),
        .busy  (mdBusy),
        .done  (mdDone)
    );

    // Load-use and branch-operand hazard detection; a held mul/div masks both.
    always_comb begin
        lu_s  = memToRegE & (reg_hit(regWriteE, writeRegE, rsD) |
                             reg_hit(regWriteE, writeRegE, rtD));
        br_s  = branchD & (reg_hit(regWriteE, writeRegE, rsD) |
                           reg_hit(regWriteE, writeRegE, rtD) |
                           reg_hit(memToRegM, writeRegM, rsD) |
                           reg_hit(memToRegM, writeRegM, rtD));
        haz_s = (lu_s | br_s) & ~hold_s;
        stall_s = hold_s | haz_s;
    end

    // Stall, flush and forwarding outputs, all quiet during reset.
    always_comb begin
        if (rst) begin
            stallF    = 1'b0;
            stallD    = 1'b0;
            stallE    = 1'b0;
            flushD    = 1'b0;
            flushE    = 1'b0;
            flushM    = 1'b0;
            forwardAE = FWD_RF;
            forwardBE = FWD_RF;
            forwardAD = 1'b0;
            forwardBD = 1'b0;
        end else begin
            stallF    = stall_s;
            stallD    = stall_s;
            stallE    = hold_s;
            flushM    = hold_s;
            flushE    = haz_s;
            // A taken branch whose operands are still stalled must not squash itself.
            flushD    = pcSrcD & ~stall_s;
            forwardAE = fwd_sel(rsE, regWriteM, writeRegM, regWriteW, writeRegW);
            forwardBE = fwd_sel(rtE, regWriteM, writeRegM, regWriteW, writeRegW);
            forwardAD = reg_hit(regWriteM, writeRegM, rsD);
            forwardBD = reg_hit(regWriteM, writeRegM, rtD);
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    // Free-running performance counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCycles <= 32'd0;
            flushCount  <= 32'd0;
        end else begin
            stallCycles <= stallCycles + {31'd0, stallD};
            flushCount  <= flushCount + {31'd0, (flushD | flushE)};
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios plus random traffic,
// checked against a cycle-count reference model.
module tb_pipeline_ctrl;

    localparam int MUL_N = 4;
    localparam int DIV_N = 32;

    typedef struct packed {
        logic       rst;
        logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
        logic       rwE, rwM, rwW, mtrE, mtrM;
        logic       branchD, pcSrcD, mdStartE, mdOpE;
    } stim_t;

    typedef struct packed {
        logic       stallF, stallD, stallE, flushD, flushE, flushM;
        logic [1:0] fAE, fBE;
        logic       fAD, fBD, mdBusy, mdDone;
    } out_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
    logic       regWriteE, regWriteM, regWriteW, memToRegE, memToRegM;
    logic       branchD, pcSrcD, mdStartE, mdOpE;
    logic       stallF, stallD, stallE, flushD, flushE, flushM;
    logic [1:0] forwardAE, forwardBE;
    logic       forwardAD, forwardBD, mdBusy, mdDone;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stallCycles, flushCount;
    logic [31:0] exp_stall = 32'd0;
    logic [31:0] exp_flush = 32'd0;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    int   md_left = 0;
    int   cyc     = 0;
    out_t exp_q[$];
    out_t dut_out;

    pipeline_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
        .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
        .memToRegE(memToRegE), .memToRegM(memToRegM),
        .branchD(branchD), .pcSrcD(pcSrcD), .mdStartE(mdStartE), .mdOpE(mdOpE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .mdBusy(mdBusy), .mdDone(mdDone)
`ifdef PIPE_CTRL_PERF_EN
       ,.stallCycles(stallCycles), .flushCount(flushCount)
`endif
    );

    assign dut_out = {stallF, stallD, stallE, flushD, flushE, flushM,
                      forwardAE, forwardBE, forwardAD, forwardBD, mdBusy, mdDone};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic hit(input logic we, input logic [4:0] dst, input logic [4:0] src);
        return we && dst != 5'd0 && dst == src;
    endfunction

    function automatic logic [1:0] fwd(input logic [4:0] src, input stim_t s);
        if (hit(s.rwM, s.wM, src)) return 2'b10;
        if (hit(s.rwW, s.wW, src)) return 2'b01;
        return 2'b00;
    endfunction

    // Reference: 'left' = stall cycles still owed to the mul/div in E.
    function automatic out_t model(input stim_t s, input int left);
        out_t o;
        logic busy, start, hold, lu, br, haz;
        o = '0;
        if (s.rst) return o;
        busy  = left > 0;
        start = !busy && s.mdStartE;
        hold  = busy || start;
        lu    = s.mtrE && (hit(s.rwE, s.wE, s.rsD) || hit(s.rwE, s.wE, s.rtD));
        br    = s.branchD && (hit(s.rwE, s.wE, s.rsD) || hit(s.rwE, s.wE, s.rtD) ||
                              hit(s.mtrM, s.wM, s.rsD) || hit(s.mtrM, s.wM, s.rtD));
        haz   = !hold && (lu || br);
        o.stallF = hold || haz;
        o.stallD = hold || haz;
        o.stallE = hold;
        o.flushM = hold;
        o.flushE = haz;
        o.flushD = s.pcSrcD && !(hold || haz);
        o.fAE    = fwd(s.rsE, s);
        o.fBE    = fwd(s.rtE, s);
        o.fAD    = hit(s.rwM, s.wM, s.rsD);
        o.fBD    = hit(s.rwM, s.wM, s.rtD);
        o.mdBusy = busy;
        o.mdDone = busy && left == 1;
        return o;
    endfunction

    task automatic step(input stim_t s, output out_t obs);
        out_t e;
        rst = s.rst; rsD = s.rsD; rtD = s.rtD; rsE = s.rsE; rtE = s.rtE;
        writeRegE = s.wE; writeRegM = s.wM; writeRegW = s.wW;
        regWriteE = s.rwE; regWriteM = s.rwM; regWriteW = s.rwW;
        memToRegE = s.mtrE; memToRegM = s.mtrM;
        branchD = s.branchD; pcSrcD = s.pcSrcD; mdStartE = s.mdStartE; mdOpE = s.mdOpE;
        e = model(s, md_left);
        exp_q.push_back(e);
        if (s.rst) md_left = 0;
        else if (md_left > 0) md_left = md_left - 1;
        else if (s.mdStartE) md_left = (s.mdOpE ? DIV_N : MUL_N) - 1;
        else md_left = 0;
`ifdef PIPE_CTRL_PERF_EN
        if (s.rst) begin
            exp_stall = 32'd0;
            exp_flush = 32'd0;
        end else begin
            exp_stall = exp_stall + {31'd0, e.stallD};
            exp_flush = exp_flush + {31'd0, (e.flushD | e.flushE)};
        end
`endif
        @(negedge clk);
        obs = dut_out;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle the DUT presents a full output vector.
    initial begin
        out_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cyc++;
                if (dut_out !== e)
                    $display("FAIL outputs cycle %0d: got %b, expected %b", cyc, dut_out, e);
                chk("outputs", 32'(dut_out), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        out_t  o;
        int    stalls, done_at, fd;
        s = '0;
        s.rst = 1'b1;
        step(s, o);
        @(posedge clk);
        #1;

        // Reset with forwarding-worthy inputs: everything must stay low.
        s = '0; s.rst = 1'b1; s.rwM = 1'b1; s.wM = 5'd3; s.rsE = 5'd3; s.rsD = 5'd3;
        s.pcSrcD = 1'b1; s.mdStartE = 1'b1;
        step(s, o);
        chk("reset outputs", 32'(o), 32'd0);

        // Load-use on r5.
        s = '0; s.mtrE = 1'b1; s.rwE = 1'b1; s.wE = 5'd5; s.rsD = 5'd5; s.rtD = 5'd2;
        step(s, o);
        chk("loaduse stall", 32'({o.stallF, o.stallD, o.flushE}), 32'd7);
        s = '0; s.mtrM = 1'b1; s.rwM = 1'b1; s.wM = 5'd5; s.rsD = 5'd5; s.rtD = 5'd2;
        step(s, o);
        chk("loaduse bubble released", 32'(o.stallD), 32'd0);
        s = '0; s.rwW = 1'b1; s.wW = 5'd5; s.rsE = 5'd5; s.rtE = 5'd2;
        step(s, o);
        chk("loaduse fwd W", 32'(o.fAE), 32'd1);

        // Forwarding priority.
        s = '0; s.rwM = 1'b1; s.wM = 5'd3; s.rwW = 1'b1; s.wW = 5'd3; s.rsE = 5'd3;
        step(s, o);
        chk("fwd M over W", 32'(o.fAE), 32'd2);
        s.rsE = 5'd0; s.wM = 5'd0;
        step(s, o);
        chk("fwd r0", 32'(o.fAE), 32'd0);

        // Branch on r7 behind a load: two stall cycles.
        stalls = 0;
        s = '0; s.branchD = 1'b1; s.rsD = 5'd7; s.mtrE = 1'b1; s.rwE = 1'b1; s.wE = 5'd7;
        step(s, o); stalls += int'(o.stallD);
        s = '0; s.branchD = 1'b1; s.rsD = 5'd7; s.mtrM = 1'b1; s.rwM = 1'b1; s.wM = 5'd7;
        step(s, o); stalls += int'(o.stallD);
        s = '0; s.branchD = 1'b1; s.rsD = 5'd7; s.pcSrcD = 1'b1; s.rwW = 1'b1; s.wW = 5'd7;
        step(s, o);
        chk("branch stall cycles", 32'(stalls), 32'd2);
        chk("branch fwdAD", 32'(o.fAD), 32'd0);
        chk("branch flushD", 32'(o.flushD), 32'd1);

        // Divide: 32 stalled cycles, mdDone in the last, no flushD.
        stalls = 0; done_at = 0; fd = 0;
        for (int i = 1; i <= DIV_N + 2; i++) begin
            s = '0; s.mdStartE = (i <= DIV_N); s.mdOpE = 1'b1; s.pcSrcD = 1'b1;
            step(s, o);
            stalls += int'(o.stallE);
            if (o.mdDone) done_at = (done_at == 0) ? i : -1;
            if (i <= DIV_N) fd += int'(o.flushD);
        end
        chk("div stallE cycles", 32'(stalls), 32'(DIV_N));
        chk("div mdDone cycle", 32'(done_at), 32'(DIV_N));
        chk("div flushD", 32'(fd), 32'd0);

        // Reset in the middle of a divide, then a multiply.
        for (int i = 1; i <= 10; i++) begin
            s = '0; s.mdStartE = 1'b1; s.mdOpE = 1'b1;
            step(s, o);
        end
        s = '0; s.rst = 1'b1; s.mdStartE = 1'b1; s.mdOpE = 1'b1;
        step(s, o);
        chk("abort reset outputs", 32'(o), 32'd0);
        s = '0;
        step(s, o);
        chk("after abort busy/stall/done", 32'({o.mdBusy, o.stallE, o.mdDone}), 32'd0);
        stalls = 0; done_at = 0;
        for (int i = 1; i <= MUL_N + 1; i++) begin
            s = '0; s.mdStartE = (i <= MUL_N);
            step(s, o);
            stalls += int'(o.stallE);
            if (o.mdDone) done_at = (done_at == 0) ? i : -1;
        end
        chk("mul stallE cycles", 32'(stalls), 32'(MUL_N));
        chk("mul mdDone cycle", 32'(done_at), 32'(MUL_N));

        // Random traffic on a small register set to provoke hazards.
        for (int i = 0; i < 800; i++) begin
            s.rst      = ($urandom_range(0, 99) == 0);
            s.rsD      = 5'($urandom_range(0, 7));
            s.rtD      = 5'($urandom_range(0, 7));
            s.rsE      = 5'($urandom_range(0, 7));
            s.rtE      = 5'($urandom_range(0, 7));
            s.wE       = 5'($urandom_range(0, 7));
            s.wM       = 5'($urandom_range(0, 7));
            s.wW       = 5'($urandom_range(0, 7));
            s.rwE      = 1'($urandom_range(0, 1));
            s.rwM      = 1'($urandom_range(0, 1));
            s.rwW      = 1'($urandom_range(0, 1));
            s.mtrE     = 1'($urandom_range(0, 1));
            s.mtrM     = 1'($urandom_range(0, 1));
            s.branchD  = 1'($urandom_range(0, 1));
            s.pcSrcD   = 1'($urandom_range(0, 1));
            s.mdStartE = ($urandom_range(0, 9) == 0);
            s.mdOpE    = 1'($urandom_range(0, 1));
            step(s, o);
        end

`ifdef PIPE_CTRL_PERF_EN
        chk("stallCycles", stallCycles, exp_stall);
        chk("flushCount", flushCount, exp_flush);
`endif
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
